// File: rtl/arvi_bus_pkg.sv
// Shared types and constants for the round-robin bus arbiter.
//   arb_state_t : arbiter FSM encoding
//   OP_W        : default atomic opcode width
//   BYTE_EN_W   : byte-enable width per master
//   slice_lo()  : low bit index of lane idx in a packed per-master bus
package arvi_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2,
    LOCKED  = 2'd3
  } arb_state_t;

  localparam int unsigned OP_W      = 7;
  localparam int unsigned BYTE_EN_W = 4;

  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
//   req     : request vector
//   ptr     : index of highest-priority requester
//   gnt_c   : one-hot selection
//   idx_c   : binary index of selection
//   valid_c : at least one request present
module rr_picker
  import arvi_bus_pkg::*;
#(
  parameter int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_c,
  output logic [IW-1:0] idx_c,
  output logic          valid_c
);

  // (ptr + off) mod N, with off < N so a single subtract suffices
  function automatic logic [IW-1:0] rot(input logic [IW-1:0] p, input int unsigned off);
    int unsigned sum;
    sum = 32'(p) + off;
    if (sum >= N) sum = sum - N;
    return IW'(sum);
  endfunction

  // Scan farthest-to-nearest so the nearest requester to ptr wins
  always_comb begin
    idx_c   = '0;
    valid_c = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[rot(ptr, 32'(i))]) begin
        idx_c   = rot(ptr, 32'(i));
        valid_c = 1'b1;
      end
    end
    gnt_c = valid_c ? (N'(1) << idx_c) : '0;
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// N-master round-robin arbiter in front of a single memory controller port.
// FSM IDLE -> GRANT -> RELEASE -> IDLE; grant/ID registered, payload muxed
// combinationally from the granted master, ack routed back in the ack cycle.
// Optional build macro ARB_LOCK_EN adds i_m_lock and a LOCKED state that keeps
// the same master granted across back-to-back atomic transactions.
// Ports:
//   i_clk, i_rst_n        : clock, async active-low reset
//   i_m_*                 : packed per-master requests/payloads (lane k at k*W)
//   o_m_ack, o_m_rd_data  : one-hot ack to granted master, broadcast read data
//   i_ack, i_rd_data      : memory controller response
//   o_bus_en .. o_operation : request to memory controller
//   o_id                  : index of granted master
module bus_arbiter_rr
  import arvi_bus_pkg::*;
#(
  parameter int unsigned N_MASTERS = 4,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned OP_W      = arvi_bus_pkg::OP_W,
  localparam int unsigned ID_W     = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1,
  localparam int unsigned BE_W     = arvi_bus_pkg::BYTE_EN_W
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [N_MASTERS-1:0]        i_m_bus_en,
  input  logic [N_MASTERS-1:0]        i_m_wr_en,
  input  logic [N_MASTERS*XLEN-1:0]   i_m_wr_data,
  input  logic [N_MASTERS*XLEN-1:0]   i_m_addr,
  input  logic [N_MASTERS*BE_W-1:0]   i_m_byte_en,
  input  logic [N_MASTERS-1:0]        i_m_atomic,
  input  logic [N_MASTERS*OP_W-1:0]   i_m_operation,
`ifdef ARB_LOCK_EN
  input  logic [N_MASTERS-1:0]        i_m_lock,
`endif
  output logic [N_MASTERS-1:0]        o_m_ack,
  output logic [XLEN-1:0]             o_m_rd_data,
  input  logic                        i_ack,
  input  logic [XLEN-1:0]             i_rd_data,
  output logic                        o_bus_en,
  output logic                        o_wr_en,
  output logic [XLEN-1:0]             o_wr_data,
  output logic [XLEN-1:0]             o_addr,
  output logic [BE_W-1:0]             o_byte_en,
  output logic                        o_atomic,
  output logic [OP_W-1:0]             o_operation,
  output logic [ID_W-1:0]             o_id
);

  arb_state_t             state_q, state_d;
  logic [ID_W-1:0]        grant_q, grant_d;
  logic [N_MASTERS-1:0]   gnt_oh_q, gnt_oh_d;
  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic                   bus_en_q;
  logic [ID_W-1:0]        ptr_next_c;
  logic                   lock_cur_c;

  logic [N_MASTERS-1:0]   pick_gnt_c;
  logic [ID_W-1:0]        pick_idx_c;
  logic                   pick_valid_c;

  // Per-master payload lanes unpacked for indexing by grant
  logic [XLEN-1:0]        wr_data_arr [N_MASTERS];
  logic [XLEN-1:0]        addr_arr    [N_MASTERS];
  logic [BE_W-1:0]        byte_en_arr [N_MASTERS];
  logic [OP_W-1:0]        op_arr      [N_MASTERS];

  for (genvar k = 0; k < int'(N_MASTERS); k++) begin : g_lane
    assign wr_data_arr[k] = i_m_wr_data[slice_lo(k, XLEN) +: XLEN];
    assign addr_arr[k]    = i_m_addr[slice_lo(k, XLEN) +: XLEN];
    assign byte_en_arr[k] = i_m_byte_en[slice_lo(k, BE_W) +: BE_W];
    assign op_arr[k]      = i_m_operation[slice_lo(k, OP_W) +: OP_W];
  end

  rr_picker #(.N(N_MASTERS)) u_picker (
    .req     (i_m_bus_en),
    .ptr     (ptr_q),
    .gnt_c   (pick_gnt_c),
    .idx_c   (pick_idx_c),
    .valid_c (pick_valid_c)
  );

  // Priority moves to the master just after the one that completed
  assign ptr_next_c = (grant_q == ID_W'(N_MASTERS - 1)) ? '0 : grant_q + ID_W'(1);

`ifdef ARB_LOCK_EN
  assign lock_cur_c = i_m_lock[grant_q];
`else
  assign lock_cur_c = 1'b0;
`endif

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      gnt_oh_q <= '0;
      ptr_q    <= '0;
      bus_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gnt_oh_q <= gnt_oh_d;
      ptr_q    <= ptr_d;
      bus_en_q <= (state_d == GRANT);
    end
  end

  // Next-state, grant and pointer update; ack routing
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gnt_oh_d = gnt_oh_q;
    ptr_d    = ptr_q;
    o_m_ack  = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid_c) begin
          grant_d  = pick_idx_c;
          gnt_oh_d = pick_gnt_c;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        if (i_ack) begin
          o_m_ack = gnt_oh_q;
          if (lock_cur_c) begin
            state_d = LOCKED;
          end else begin
            state_d = RELEASE;
            ptr_d   = ptr_next_c;
          end
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
`ifdef ARB_LOCK_EN
      LOCKED: begin
        if (!lock_cur_c) begin
          state_d = RELEASE;
          ptr_d   = ptr_next_c;
        end else if (i_m_bus_en[grant_q]) begin
          state_d = GRANT;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_bus_en    = bus_en_q;
  assign o_id        = grant_q;
  assign o_m_rd_data = i_rd_data;
  assign o_wr_en     = i_m_wr_en[grant_q];
  assign o_wr_data   = wr_data_arr[grant_q];
  assign o_addr      = addr_arr[grant_q];
  assign o_byte_en   = byte_en_arr[grant_q];
  assign o_atomic    = i_m_atomic[grant_q];
  assign o_operation = op_arr[grant_q];

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed self-checking bench for bus_arbiter_rr (N_MASTERS=4, XLEN=32).
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_bus_arbiter_rr;

  localparam int unsigned N    = 4;
  localparam int unsigned XLEN = 32;
  localparam int unsigned OP_W = 7;
  localparam int unsigned ID_W = 2;

  logic                 i_clk = 1'b0;
  logic                 i_rst_n;
  logic [N-1:0]         i_m_bus_en;
  logic [N-1:0]         i_m_wr_en;
  logic [N*XLEN-1:0]    i_m_wr_data;
  logic [N*XLEN-1:0]    i_m_addr;
  logic [N*4-1:0]       i_m_byte_en;
  logic [N-1:0]         i_m_atomic;
  logic [N*OP_W-1:0]    i_m_operation;
`ifdef ARB_LOCK_EN
  logic [N-1:0]         i_m_lock;
`endif
  logic [N-1:0]         o_m_ack;
  logic [XLEN-1:0]      o_m_rd_data;
  logic                 i_ack;
  logic [XLEN-1:0]      i_rd_data;
  logic                 o_bus_en;
  logic                 o_wr_en;
  logic [XLEN-1:0]      o_wr_data;
  logic [XLEN-1:0]      o_addr;
  logic [3:0]           o_byte_en;
  logic                 o_atomic;
  logic [OP_W-1:0]      o_operation;
  logic [ID_W-1:0]      o_id;

  int n_cmp = 0;
  int n_err = 0;

  bus_arbiter_rr #(.N_MASTERS(N), .XLEN(XLEN), .OP_W(OP_W)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_m_bus_en    (i_m_bus_en),
    .i_m_wr_en     (i_m_wr_en),
    .i_m_wr_data   (i_m_wr_data),
    .i_m_addr      (i_m_addr),
    .i_m_byte_en   (i_m_byte_en),
    .i_m_atomic    (i_m_atomic),
    .i_m_operation (i_m_operation),
`ifdef ARB_LOCK_EN
    .i_m_lock      (i_m_lock),
`endif
    .o_m_ack       (o_m_ack),
    .o_m_rd_data   (o_m_rd_data),
    .i_ack         (i_ack),
    .i_rd_data     (i_rd_data),
    .o_bus_en      (o_bus_en),
    .o_wr_en       (o_wr_en),
    .o_wr_data     (o_wr_data),
    .o_addr        (o_addr),
    .o_byte_en     (o_byte_en),
    .o_atomic      (o_atomic),
    .o_operation   (o_operation),
    .o_id          (o_id)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_lane(input int k, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic wr);
    i_m_addr[k*XLEN +: XLEN]    = addr;
    i_m_wr_data[k*XLEN +: XLEN] = wdata;
    i_m_wr_en[k]                = wr;
    i_m_byte_en[k*4 +: 4]       = 4'hF;
  endtask

  int exp_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    i_rst_n       = 1'b0;
    i_m_bus_en    = '0;
    i_m_wr_en     = '0;
    i_m_wr_data   = '0;
    i_m_addr      = '0;
    i_m_byte_en   = '0;
    i_m_atomic    = '0;
    i_m_operation = '0;
`ifdef ARB_LOCK_EN
    i_m_lock      = '0;
`endif
    i_ack         = 1'b0;
    i_rd_data     = '0;
    for (int k = 0; k < int'(N); k++)
      set_lane(k, 32'h100 * k, 32'hCAFE_0000 + k, 1'b1);

    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    check_eq("rst_bus_en", 64'(o_bus_en), 64'd0);
    check_eq("rst_id", 64'(o_id), 64'd0);
    check_eq("rst_ack", 64'(o_m_ack), 64'd0);

    // Single request from m2: grant next cycle, ack at t+3, release at t+4
    i_m_bus_en = 4'b0100;
    step();
    i_m_bus_en = 4'b0000;
    check_eq("m2_bus_en", 64'(o_bus_en), 64'd1);
    check_eq("m2_id", 64'(o_id), 64'd2);
    check_eq("m2_addr", 64'(o_addr), 64'h200);
    check_eq("m2_wdata", 64'(o_wr_data), 64'hCAFE_0002);
    step();
    check_eq("m2_hold", 64'(o_bus_en), 64'd1);
    step();
    i_ack = 1'b1;
    i_rd_data = 32'h1234_5678;
    #1;
    check_eq("m2_ack", 64'(o_m_ack), 64'b0100);
    check_eq("m2_rdata", 64'(o_m_rd_data), 64'h1234_5678);
    step();
    i_ack = 1'b0;
    check_eq("m2_release", 64'(o_bus_en), 64'd0);
    step();

    // Spurious ack in IDLE
    i_ack = 1'b1;
    #1;
    check_eq("spur_ack", 64'(o_m_ack), 64'd0);
    step();
    check_eq("spur_bus_en", 64'(o_bus_en), 64'd0);
    check_eq("spur_ack2", 64'(o_m_ack), 64'd0);
    i_ack = 1'b0;

    // Reset pulse returns pointer to master 0
    i_rst_n = 1'b0;
    #2;
    i_rst_n = 1'b1;
    check_eq("pulse_id", 64'(o_id), 64'd0);

    // All four requesting with 1-cycle memory: strict rotation
    i_m_bus_en = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      step();
      check_eq($sformatf("rot%0d_bus_en", t), 64'(o_bus_en), 64'd1);
      check_eq($sformatf("rot%0d_id", t), 64'(o_id), 64'(exp_order[t]));
      i_ack = 1'b1;
      #1;
      check_eq($sformatf("rot%0d_ack", t), 64'(o_m_ack), 64'(4'b0001 << exp_order[t]));
      step();
      i_ack = 1'b0;
      check_eq($sformatf("rot%0d_rel", t), 64'(o_bus_en), 64'd0);
      step();
    end

    // m1 drops its request mid-GRANT: grant held until ack
    i_m_bus_en = 4'b0010;
    step();
    check_eq("drop_id", 64'(o_id), 64'd1);
    i_m_bus_en = 4'b0000;
    step();
    check_eq("drop_bus_en", 64'(o_bus_en), 64'd1);
    check_eq("drop_addr", 64'(o_addr), 64'h100);
    i_ack = 1'b1;
    #1;
    check_eq("drop_ack", 64'(o_m_ack), 64'b0010);
    step();
    i_ack = 1'b0;
    step();

    // Async reset during GRANT of m3, then m0 wins over m3
    i_m_bus_en = 4'b1000;
    step();
    check_eq("rg_id", 64'(o_id), 64'd3);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_eq("rg_bus_en", 64'(o_bus_en), 64'd0);
    check_eq("rg_id_rst", 64'(o_id), 64'd0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    i_m_bus_en = 4'b1001;
    step();
    check_eq("post_rst_id", 64'(o_id), 64'd0);
    i_ack = 1'b1;
    #1;
    check_eq("post_rst_ack", 64'(o_m_ack), 64'b0001);
    step();
    i_ack = 1'b0;
    i_m_bus_en = 4'b0000;
    step();

`ifdef ARB_LOCK_EN
    // Locked LR/SC pair from m3 while m0 competes
    i_m_bus_en = 4'b1001;
    i_m_lock   = 4'b1000;
    step();
    check_eq("lk_lr_id", 64'(o_id), 64'd3);
    i_ack = 1'b1;
    #1;
    check_eq("lk_lr_ack", 64'(o_m_ack), 64'b1000);
    step();
    i_ack = 1'b0;
    check_eq("lk_wait_bus_en", 64'(o_bus_en), 64'd0);
    check_eq("lk_wait_id", 64'(o_id), 64'd3);
    step();
    check_eq("lk_sc_bus_en", 64'(o_bus_en), 64'd1);
    check_eq("lk_sc_id", 64'(o_id), 64'd3);
    i_m_lock = 4'b0000;
    i_ack = 1'b1;
    #1;
    check_eq("lk_sc_ack", 64'(o_m_ack), 64'b1000);
    step();
    i_ack = 1'b0;
    i_m_bus_en = 4'b0001;
    check_eq("lk_rel", 64'(o_bus_en), 64'd0);
    step();
    step();
    check_eq("lk_m0_id", 64'(o_id), 64'd0);
    i_ack = 1'b1;
    #1;
    check_eq("lk_m0_ack", 64'(o_m_ack), 64'b0001);
    step();
    i_ack = 1'b0;
    i_m_bus_en = 4'b0000;
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
N-master round-robin arbiter between per-hart bus masters and the single memory_controller port. Generalises the fixed 2-input arbiter to N_MASTERS harts. Adds fair rotating priority, a registered grant/ID, a release cycle, and optional locked back-to-back grants for atomic sequences.

Parameters:
N_MASTERS, 4, number of requesting masters (>=1)
XLEN, 32, data/address width
OP_W, 7, atomic operation field width
ID_W, localparam max(1,$clog2(N_MASTERS)), width of o_id

Ports:
i_clk  in  1  clock
i_rst_n  in  1  async reset, active-low
i_m_bus_en  in  N_MASTERS  per-master request
i_m_wr_en  in  N_MASTERS  per-master write enable
i_m_wr_data  in  N_MASTERS*XLEN  packed write data, master k at [k*XLEN +: XLEN]
i_m_addr  in  N_MASTERS*XLEN  packed address
i_m_byte_en  in  N_MASTERS*4  packed byte enables
i_m_atomic  in  N_MASTERS  atomic flag
i_m_operation  in  N_MASTERS*OP_W  packed atomic opcode
o_m_ack  out  N_MASTERS  one-hot ack to granted master
o_m_rd_data  out  XLEN  read data, broadcast
i_ack  in  1  ack from memory_controller
i_rd_data  in  XLEN  read data from memory_controller
o_bus_en, o_wr_en  out  1 each  to memory_controller
o_wr_data, o_addr  out  XLEN each  to memory_controller
o_byte_en  out  4  to memory_controller
o_atomic  out  1  to memory_controller
o_operation  out  OP_W  to memory_controller
o_id  out  ID_W  index of granted master

Behaviour:
- Single clock i_clk; asynchronous active-low reset i_rst_n.
- Reset: state IDLE, grant=0, o_id=0, o_bus_en=0, o_m_ack=0, priority pointer=0 (master 0 highest). Reset mid-transaction drops o_bus_en immediately; the in-flight ack is lost.
- FSM IDLE -> GRANT -> RELEASE -> IDLE.
- IDLE: if any i_m_bus_en is set, pick the first requester at or after the pointer, wrapping modulo N_MASTERS. Register grant and o_id, go to GRANT. Latency: request at cycle t gives o_bus_en=1 at t+1.
- GRANT: o_bus_en=1 is held by state, not by the master. o_wr_en, o_wr_data, o_addr, o_byte_en, o_atomic and o_operation are muxed combinationally from the granted master.
  - On i_ack: o_m_ack[grant]=1 in the same cycle; o_m_rd_data=i_rd_data (always passed through); pointer <= grant+1 mod N; go to RELEASE.
- Granted master drops bus_en before ack: grant and o_bus_en are held until i_ack, and the ack is still routed.
- RELEASE: one cycle. All requests ignored, o_bus_en=0, then IDLE. This lets masters deassert bus_en after their ack.
- i_ack outside GRANT: ignored, o_m_ack stays 0.
- Simultaneous requests: strict rotation. With all N masters requesting continuously, each master is served once per N transactions. Worst-case wait = N*(txn+2) cycles.
- N_MASTERS=1: o_id is constant 0; the pointer is unused.
- o_m_ack is never multi-hot.

Optional Feature:
ARB_LOCK_EN:
- Defined: adds input i_m_lock [N_MASTERS].
  - If i_m_lock[grant] is 1 at the ack cycle, the FSM skips RELEASE and the pointer update and returns to GRANT for the same master at the next cycle where its bus_en is 1. It waits in a LOCKED state with o_bus_en=0 meanwhile.
  - Deasserting lock in LOCKED, or at the ack cycle, goes to RELEASE and advances the pointer normally.
- Undefined: no port, no LOCKED state; every transaction re-arbitrates.

Decomposition:
- Package arvi_bus_pkg: arb_state_t enum (IDLE, GRANT, RELEASE, LOCKED), OP_W and BYTE_EN_W constants, and a function for the packed-slice index.
- Sub-module rr_picker #(N): combinational; inputs request vector and pointer; outputs one-hot grant, binary index and valid flag.

Test Plan:
- Reset then single request m2 at t -> o_bus_en=1, o_id=2 at t+1; i_ack at t+3 -> o_m_ack=4'b0100 the same cycle; o_bus_en=0 at t+4 (RELEASE).
- All four requesting continuously, 1-cycle-latency memory -> grant order 0,1,2,3,0; no master served twice in a window of 4.
- m1 request drops mid-GRANT with addr 0x100 -> o_bus_en stays 1 until i_ack, then o_m_ack[1]=1.
- Spurious i_ack in IDLE -> o_m_ack=0; no state change.
- i_rst_n low during GRANT -> o_bus_en=0 asynchronously; after release, m0 has first priority.
- ARB_LOCK_EN: m3 with lock=1 does LR then SC -> both granted consecutively, o_id=3 throughout, competing m0 served only after lock drops.
